ram_burst_ctrl: RTL



---
 rtl/ram_burst_ctrl.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/ram_burst_ctrl.sv
// Burst front-end for a single-port RAM: turns write/read burst commands into
// per-beat RAM strobes and buffers read results in a show-ahead response FIFO.
module ram_burst_ctrl #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_BUS_WIDTH = 4,
    parameter int RD_LATENCY     = 2,
    parameter int RSP_FIFO_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [ADDR_BUS_WIDTH-1:0] cmd_addr,
    input  logic [ADDR_BUS_WIDTH-1:0] cmd_len,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    input  logic [DATA_WIDTH-1:0]     wr_data,
    output logic                      rd_valid,
    input  logic                      rd_ready,
    output logic [DATA_WIDTH-1:0]     rd_data,
    output logic                      busy,
    output logic [ADDR_BUS_WIDTH-1:0] address_loc,
    output logic [DATA_WIDTH-1:0]     data_inbit,
    output logic                      write_en,
    output logic                      read_en,
    input  logic [DATA_WIDTH-1:0]     data_outbit
);

    localparam int PTR_W = (RSP_FIFO_DEPTH > 1) ? $clog2(RSP_FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(RSP_FIFO_DEPTH + 1);
    localparam int SUM_W = $clog2(RSP_FIFO_DEPTH + RD_LATENCY + 1);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ,
        DRAIN
    } state_t;

    state_t                    state_reg, state_next;
    logic [ADDR_BUS_WIDTH-1:0] cur_addr_reg, cur_addr_next;
    logic [ADDR_BUS_WIDTH-1:0] remain_reg, remain_next;
    logic [ADDR_BUS_WIDTH-1:0] address_loc_reg, address_loc_next;
    logic [DATA_WIDTH-1:0]     data_inbit_reg, data_inbit_next;
    logic                      write_en_reg, write_en_next;
    logic                      read_en_reg, read_en_next;
    logic                      issue;

    logic                      vld_reg [RD_LATENCY];
    logic [SUM_W-1:0]          inflight;
    logic [SUM_W-1:0]          credit_sum;
    logic                      credit_ok;

    logic [DATA_WIDTH-1:0]     fifo_mem [RSP_FIFO_DEPTH];
    logic [PTR_W-1:0]          wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]          count_reg;
    logic                      push, pop, fifo_empty;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RSP_FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // One valid bit per outstanding read; the last tap lines up with data_outbit.
    genvar gi;
    generate
        for (gi = 0; gi < RD_LATENCY; gi++) begin : g_vld
            if (gi == 0) begin : g_head
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) vld_reg[gi] <= 1'b0;
                    else        vld_reg[gi] <= issue;
                end
            end else begin : g_tail
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) vld_reg[gi] <= 1'b0;
                    else        vld_reg[gi] <= vld_reg[gi-1];
                end
            end
        end
    endgenerate

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            inflight = inflight + SUM_W'(vld_reg[i]);
        end
    end

    // Every in-flight read already owns a FIFO slot, so pushes can never overflow.
    assign credit_sum = inflight + SUM_W'(count_reg);
    assign credit_ok  = credit_sum < SUM_W'(RSP_FIFO_DEPTH);

    assign push       = vld_reg[RD_LATENCY-1];
    assign fifo_empty = (count_reg == '0);
    assign pop        = !fifo_empty && rd_ready;

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_reg] <= data_outbit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            if (pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            cur_addr_reg    <= '0;
            remain_reg      <= '0;
            address_loc_reg <= '0;
            data_inbit_reg  <= '0;
            write_en_reg    <= 1'b0;
            read_en_reg     <= 1'b0;
        end else begin
            state_reg       <= state_next;
            cur_addr_reg    <= cur_addr_next;
            remain_reg      <= remain_next;
            address_loc_reg <= address_loc_next;
            data_inbit_reg  <= data_inbit_next;
            write_en_reg    <= write_en_next;
            read_en_reg     <= read_en_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        cur_addr_next    = cur_addr_reg;
        remain_next      = remain_reg;
        address_loc_next = address_loc_reg;
        data_inbit_next  = data_inbit_reg;
        write_en_next    = 1'b0;
        read_en_next     = 1'b0;
        issue            = 1'b0;
        case (state_reg)
            IDLE: begin
                if (cmd_valid) begin
                    cur_addr_next = cmd_addr;
                    remain_next   = cmd_len;
                    state_next    = cmd_write ? WRITE : READ;
                end
            end
            WRITE: begin
                if (wr_valid) begin
                    write_en_next    = 1'b1;
                    address_loc_next = cur_addr_reg;
                    data_inbit_next  = wr_data;
                    cur_addr_next    = cur_addr_reg + ADDR_BUS_WIDTH'(1);
                    remain_next      = remain_reg - ADDR_BUS_WIDTH'(1);
                    if (remain_reg == '0) state_next = IDLE;
                end
            end
            READ: begin
                if (credit_ok) begin
                    issue            = 1'b1;
                    read_en_next     = 1'b1;
                    address_loc_next = cur_addr_reg;
                    cur_addr_next    = cur_addr_reg + ADDR_BUS_WIDTH'(1);
                    remain_next      = remain_reg - ADDR_BUS_WIDTH'(1);
                    if (remain_reg == '0) state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (inflight == '0) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign cmd_ready   = (state_reg == IDLE);
    assign wr_ready    = (state_reg == WRITE);
    assign busy        = (state_reg != IDLE) || !fifo_empty;
    assign rd_valid    = !fifo_empty;
    assign rd_data     = fifo_empty ? '0 : fifo_mem[rd_ptr_reg];
    assign address_loc = address_loc_reg;
    assign data_inbit  = data_inbit_reg;
    assign write_en    = write_en_reg;
    assign read_en     = read_en_reg;

endmodule
